// File: rtl/dcache_refill_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Holds the FSM state encoding and the default geometry and address-field widths.
package dcache_refill_pkg;

    localparam int unsigned AW        = 16;
    localparam int unsigned DW        = 16;
    localparam int unsigned DEF_LINES = 64;
    localparam int unsigned DEF_WORDS = 4;
    localparam int unsigned DEF_IW    = $clog2(DEF_LINES);
    localparam int unsigned DEF_OW    = $clog2(DEF_WORDS);
    localparam int unsigned DEF_TW    = AW - DEF_IW - DEF_OW;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFill  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;

endpackage

// File: rtl/dcache_refill_if.sv
// CPU-side and memory-side signals of the data cache, bundled as one interface.
// slave = the cache itself; master = the CPU plus the backing memory around it.
interface dcache_refill_if;
    logic        re;
    logic        we;
    logic [15:0] d_addr;
    logic [15:0] wrt_data;
    logic [15:0] d_data;
    logic        d_hit;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rdy;

    modport slave (
        input  re, we, d_addr, wrt_data, mem_rdata, mem_rdy,
        output d_data, d_hit, mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output re, we, d_addr, wrt_data, mem_rdata, mem_rdy,
        input  d_data, d_hit, mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_refill_array.sv
// Tag, valid and data storage for the data cache.
// One write port, one combinational read port; only the valid vector is reset.
module dcache_array
    import dcache_refill_pkg::*;
#(
    parameter int unsigned LINES = DEF_LINES,
    parameter int unsigned WORDS = DEF_WORDS,
    localparam int unsigned IW   = $clog2(LINES),
    localparam int unsigned OW   = $clog2(WORDS),
    localparam int unsigned TW   = AW - IW - OW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] rd_idx,
    input  logic [OW-1:0] rd_off,
    input  logic [TW-1:0] rd_tag,
    output logic          rd_hit,
    output logic [DW-1:0] rd_word,
    input  logic [IW-1:0] wr_idx,
    input  logic          data_we,
    input  logic [OW-1:0] wr_off,
    input  logic [DW-1:0] wr_word,
    input  logic          valid_we,
    input  logic          valid_val,
    input  logic [TW-1:0] wr_tag
);

    logic [DW-1:0]    data_mem [LINES*WORDS];
    logic [TW-1:0]    tag_mem  [LINES];
    logic [LINES-1:0] valid_q;

    assign rd_word = data_mem[{rd_idx, rd_off}];
    assign rd_hit  = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[{wr_idx, wr_off}] <= wr_word;
        end
        if (valid_we && valid_val) begin
            tag_mem[wr_idx] <= wr_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (valid_we) begin
            valid_q[wr_idx] <= valid_val;
        end
    end

endmodule

// File: rtl/dcache_refill.sv
// Direct-mapped, write-through, no-write-allocate data cache with line refill.
// Stalls the CPU (d_hit=0) during refills and write-through stores.
module dcache_refill
    import dcache_refill_pkg::*;
#(
    parameter int unsigned LINES = DEF_LINES,
    parameter int unsigned WORDS = DEF_WORDS
) (
    input  logic            clk,
    input  logic            rst,
    dcache_refill_if.slave  bus
);

    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned OW = $clog2(WORDS);
    localparam int unsigned TW = AW - IW - OW;
    localparam logic [OW-1:0] LastBeat = OW'(WORDS - 1);
    localparam logic [OW-1:0] OffOne   = OW'(1);

    logic [1:0]    state_q, state_d;
    logic [OW-1:0] cnt_q, cnt_d;
    logic          mem_re_q, mem_re_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic [AW-1:0] look_addr;
    logic          look_hit;
    logic [DW-1:0] look_word;
    logic          load_hit;

    logic [IW-1:0] wr_idx;
    logic          data_we;
    logic [OW-1:0] wr_off;
    logic [DW-1:0] wr_word;
    logic          valid_we;
    logic          valid_val;
    logic [TW-1:0] wr_tag;

    // A pending store looks up its own latched address; otherwise the CPU address is used.
    assign look_addr = (state_q == StWrite) ? mem_addr_q : bus.d_addr;
    assign wr_tag    = mem_addr_q[AW-1:IW+OW];

    dcache_array #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (look_addr[IW+OW-1:OW]),
        .rd_off    (look_addr[OW-1:0]),
        .rd_tag    (look_addr[AW-1:IW+OW]),
        .rd_hit    (look_hit),
        .rd_word   (look_word),
        .wr_idx    (wr_idx),
        .data_we   (data_we),
        .wr_off    (wr_off),
        .wr_word   (wr_word),
        .valid_we  (valid_we),
        .valid_val (valid_val),
        .wr_tag    (wr_tag)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_idx      = mem_addr_q[IW+OW-1:OW];
        data_we     = 1'b0;
        wr_off      = mem_addr_q[OW-1:0];
        wr_word     = mem_wdata_q;
        valid_we    = 1'b0;
        valid_val   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.we) begin
                    state_d     = StWrite;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.wrt_data;
                end else if (bus.re && !look_hit) begin
                    state_d    = StFill;
                    cnt_d      = '0;
                    mem_re_d   = 1'b1;
                    mem_addr_d = {bus.d_addr[AW-1:OW], {OW{1'b0}}};
                    // Drop the victim now so an aborted refill never leaves a stale-valid line.
                    wr_idx     = bus.d_addr[IW+OW-1:OW];
                    valid_we   = 1'b1;
                    valid_val  = 1'b0;
                end
            end
            StFill: begin
                if (bus.mem_rdy) begin
                    data_we = 1'b1;
                    wr_off  = cnt_q;
                    wr_word = bus.mem_rdata;
                    if (cnt_q == LastBeat) begin
                        valid_we  = 1'b1;
                        valid_val = 1'b1;
                        mem_re_d  = 1'b0;
                        state_d   = StIdle;
                    end else begin
                        cnt_d      = cnt_q + OffOne;
                        mem_addr_d = {mem_addr_q[AW-1:OW], cnt_q + OffOne};
                    end
                end
            end
            StWrite: begin
                if (bus.mem_rdy) begin
                    mem_we_d = 1'b0;
                    state_d  = StIdle;
                    data_we  = look_hit;
                end
            end
            default: begin
                state_d  = StIdle;
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign load_hit      = (state_q == StIdle) && bus.re && !bus.we && look_hit;
    assign bus.d_hit     = (!bus.re && !bus.we) || load_hit ||
                           ((state_q == StWrite) && bus.mem_rdy);
    assign bus.d_data    = load_hit ? look_word : '0;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
